// File: rtl/dcp_bus_ctl_if.sv
// Host/DCP bus bundle for dcp_bus_ctl. The controller connects to the slave modport;
// the host side and the DCP model connect to the master modport.
interface dcp_bus_ctl_if #(
    parameter int DW = 8
);
    logic          rd_req;
    logic          wr_req;
    logic          la;
    logic [DW-1:0] wdata;
    logic          dcp_rdy;
    logic [DW-1:0] dcp_din;
    logic          mas;
    logic          mds;
    logic          dcp_we;
    logic [DW-1:0] dcp_dout;
    logic [DW-1:0] rdata;
    logic          ack;
    logic          err;
    logic          busy;
    logic          tick;

    modport master (
        output rd_req, wr_req, la, wdata, dcp_rdy, dcp_din,
        input  mas, mds, dcp_we, dcp_dout, rdata, ack, err, busy, tick
    );

    modport slave (
        input  rd_req, wr_req, la, wdata, dcp_rdy, dcp_din,
        output mas, mds, dcp_we, dcp_dout, rdata, ack, err, busy, tick
    );
endinterface

// File: rtl/dcp_bus_ctl.sv
// DCP bus cycle controller: a prescaled tick paces a strobe of fixed minimum width,
// then waits for dcp_rdy with a tick-based timeout. Every output is a flop.
module dcp_bus_ctl #(
    parameter int PRE_W     = 2,
    parameter int STB_TICKS = 2,
    parameter int TMO_TICKS = 15,
    parameter int DW        = 8
) (
    input  logic         clk,
    input  logic         reset,
    dcp_bus_ctl_if.slave bus
);
    // state  | meaning
    // IDLE   | no transaction, accepting rd_req / wr_req
    // SYNC   | request latched, waiting for a tick to align the strobe
    // STROBE | mas or mds high, counting STB_TICKS ticks
    // WAIT   | strobe still high, waiting for dcp_rdy or TMO_TICKS ticks
    // DONE   | strobes low, one-clock ack (err on timeout)
    typedef enum logic [2:0] {IDLE, SYNC, STROBE, WAIT, DONE} state_t;

    localparam logic [7:0] STB_LOAD = 8'(STB_TICKS);
    localparam logic [7:0] TMO_LOAD = 8'(TMO_TICKS);

    state_t        state;
    logic [PRE_W-1:0] pre_cnt;
    logic [PRE_W-1:0] pre_nxt;
    logic          tick_q;
    logic [7:0]    tmr;
    logic          la_q;
    logic          dir_q;
    logic          mas_q;
    logic          mds_q;
    logic          we_q;
    logic          ack_q;
    logic          err_q;
    logic          busy_q;
    logic [DW-1:0] dout_q;
    logic [DW-1:0] rdata_q;

    assign pre_nxt = pre_cnt + PRE_W'(1);

    // tick is registered from the next count so it is high exactly while count is all-ones
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt <= '0;
            tick_q  <= 1'b0;
        end else begin
            pre_cnt <= pre_nxt;
            tick_q  <= &pre_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            tmr     <= '0;
            la_q    <= 1'b0;
            dir_q   <= 1'b0;
            mas_q   <= 1'b0;
            mds_q   <= 1'b0;
            we_q    <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            dout_q  <= '0;
            rdata_q <= '0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.rd_req || bus.wr_req) begin
                        la_q   <= bus.la;
                        dir_q  <= bus.wr_req;
                        dout_q <= bus.wdata;
                        busy_q <= 1'b1;
                        state  <= SYNC;
                    end
                end
                SYNC: begin
                    if (tick_q) begin
                        mas_q <= la_q;
                        mds_q <= !la_q;
                        we_q  <= dir_q;
                        tmr   <= STB_LOAD;
                        state <= STROBE;
                    end
                end
                STROBE: begin
                    if (tick_q) begin
                        if (tmr == 8'd1) begin
                            tmr   <= TMO_LOAD;
                            state <= WAIT;
                        end else begin
                            tmr <= tmr - 8'd1;
                        end
                    end
                end
                WAIT: begin
                    // ready beats a timeout landing on the same clock
                    if (bus.dcp_rdy) begin
                        if (!dir_q) rdata_q <= bus.dcp_din;
                        mas_q <= 1'b0;
                        mds_q <= 1'b0;
                        we_q  <= 1'b0;
                        ack_q <= 1'b1;
                        state <= DONE;
                    end else if (tick_q) begin
                        if (tmr == 8'd1) begin
                            mas_q <= 1'b0;
                            mds_q <= 1'b0;
                            we_q  <= 1'b0;
                            ack_q <= 1'b1;
                            err_q <= 1'b1;
                            state <= DONE;
                        end else begin
                            tmr <= tmr - 8'd1;
                        end
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mas      = mas_q;
    assign bus.mds      = mds_q;
    assign bus.dcp_we   = we_q;
    assign bus.dcp_dout = dout_q;
    assign bus.rdata    = rdata_q;
    assign bus.ack      = ack_q;
    assign bus.err      = err_q;
    assign bus.busy     = busy_q;
    assign bus.tick     = tick_q;
endmodule

// File: tb/tb_dcp_bus_ctl.sv
// Bench for dcp_bus_ctl: a default instance (A) and a PRE_W=3/STB_TICKS=1 instance (B)
// share directed stimulus; a timeline model predicts every output on every cycle.
module tb_dcp_bus_ctl;
    localparam int TMO = 15;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dcp_bus_ctl_if #(.DW(8)) bus_a ();
    dcp_bus_ctl_if #(.DW(8)) bus_b ();

    dcp_bus_ctl #(.PRE_W(2), .STB_TICKS(2), .TMO_TICKS(TMO), .DW(8)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a));
    dcp_bus_ctl #(.PRE_W(3), .STB_TICKS(1), .TMO_TICKS(TMO), .DW(8)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b));

    logic [22:0] act_a;
    logic [22:0] act_b;
    assign act_a = {bus_a.mas, bus_a.mds, bus_a.dcp_we, bus_a.ack, bus_a.err, bus_a.busy,
                    bus_a.tick, bus_a.dcp_dout, bus_a.rdata};
    assign act_b = {bus_b.mas, bus_b.mds, bus_b.dcp_we, bus_b.ack, bus_b.err, bus_b.busy,
                    bus_b.tick, bus_b.dcp_dout, bus_b.rdata};

    int n_chk = 0;
    int n_pass = 0;
    int kc = 0;
    bit m_valid = 0;

    // scenario stimulus, all in cycles counted from the last reset
    int s_rd0, s_rd1, s_wr0, s_rst, s_dsw, s_r1lo, s_r1hi, s_r2lo, s_r2hi;
    bit s_la;
    bit rst_done;
    logic [7:0] s_wd, s_din0, s_din1;

    // model: one transaction timeline per instance
    int m_pw [2];
    int m_stb [2];
    bit m_act [2];
    int m_r [2];
    int m_s [2];
    int m_d [2];
    bit m_la [2];
    bit m_dir [2];
    bit m_to [2];
    logic [7:0] m_din [2];
    logic [7:0] m_rdata [2];
    logic [7:0] m_dout [2];

    // observations for the literal expectations
    int a_ack_cnt, a_ack_first, a_ack_last, a_err_last, a_mas_first, a_mas_last;
    int a_mds_cnt, a_we_first, a_we_last, a_busy_first;
    int b_mas_first, b_ack_first, b_tick1, b_tick2;
    bit abort_seen;
    logic [22:0] a_abort_vec;

    function automatic bit rdy_at(int c);
        return (c >= s_r1lo && c < s_r1hi) || (c >= s_r2lo && c < s_r2hi);
    endfunction

    function automatic logic [7:0] din_at(int c);
        return (c < s_dsw) ? s_din0 : s_din1;
    endfunction

    function automatic logic [22:0] exp_vec(int i, int c);
        int p;
        bit busy, stb_on, ack, tk;
        p = 1 << m_pw[i];
        busy = m_act[i] && c > m_r[i] && c <= m_d[i];
        stb_on = m_act[i] && c >= m_s[i] && c < m_d[i];
        ack = m_act[i] && c == m_d[i];
        tk = (c % p) == p - 1;
        return {stb_on && m_la[i], stb_on && !m_la[i], stb_on && m_dir[i], ack,
                ack && m_to[i], busy, tk, m_dout[i], m_rdata[i]};
    endfunction

    // request accepted at cycle c: strobe starts after the next tick, lasts STB ticks,
    // then the first ready cycle within TMO ticks ends it, else the last tick does
    task automatic accept(int i, int c, bit dir);
        int p, t0, w, tto, cr;
        p = 1 << m_pw[i];
        t0 = c + 1;
        while (t0 % p != p - 1) t0++;
        m_act[i] = 1;
        m_r[i] = c;
        m_s[i] = t0 + 1;
        m_la[i] = s_la;
        m_dir[i] = dir;
        m_dout[i] = s_wd;
        w = m_s[i] + m_stb[i] * p;
        tto = w + TMO * p - 1;
        cr = -1;
        for (int k = w; k <= tto && cr < 0; k++) if (rdy_at(k)) cr = k;
        if (cr >= 0) begin
            m_d[i] = cr + 1;
            m_to[i] = 0;
            m_din[i] = din_at(cr);
        end else begin
            m_d[i] = tto + 1;
            m_to[i] = 1;
            m_din[i] = '0;
        end
    endtask

    task automatic record();
        if (bus_a.ack) begin
            a_ack_cnt++;
            if (a_ack_first < 0) a_ack_first = kc;
            a_ack_last = kc;
            a_err_last = int'(bus_a.err);
        end
        if (bus_a.mas) begin
            if (a_mas_first < 0) a_mas_first = kc;
            a_mas_last = kc;
        end
        if (bus_a.mds) a_mds_cnt++;
        if (bus_a.dcp_we) begin
            if (a_we_first < 0) a_we_first = kc;
            a_we_last = kc;
        end
        if (bus_a.busy && a_busy_first < 0) a_busy_first = kc;
        if (bus_b.mas && b_mas_first < 0) b_mas_first = kc;
        if (bus_b.ack && b_ack_first < 0) b_ack_first = kc;
        if (bus_b.tick) begin
            if (b_tick1 < 0) b_tick1 = kc;
            else if (b_tick2 < 0) b_tick2 = kc;
        end
        if (rst_done && kc == 0 && !abort_seen) begin
            abort_seen = 1;
            a_abort_vec = act_a;
        end
    endtask

    task automatic clear_obs();
        a_ack_cnt = 0; a_ack_first = -1; a_ack_last = -1; a_err_last = -1;
        a_mas_first = -1; a_mas_last = -1; a_mds_cnt = 0; a_we_first = -1; a_we_last = -1;
        a_busy_first = -1; b_mas_first = -1; b_ack_first = -1; b_tick1 = -1; b_tick2 = -1;
        abort_seen = 0; a_abort_vec = '1;
    endtask

    // one cycle: compare outputs of cycle kc, drive inputs for kc, advance a clock
    task automatic step(bit force_rst);
        bit rd, wr, rst;
        logic [22:0] act [2];
        logic [22:0] ev;
        act[0] = act_a;
        act[1] = act_b;
        if (m_valid) begin
            for (int i = 0; i < 2; i++) begin
                if (m_act[i] && kc == m_d[i] && !m_dir[i] && !m_to[i]) m_rdata[i] = m_din[i];
                ev = exp_vec(i, kc);
                n_chk++;
                if (act[i] === ev) n_pass++;
                else $display("FAIL cycle_%s k=%0d got=%h exp=%h", (i == 0) ? "A" : "B", kc, act[i], ev);
            end
            record();
        end
        rst = force_rst || (!rst_done && kc == s_rst);
        if (rst && !force_rst) rst_done = 1;
        rd = (kc == s_rd0) || (kc == s_rd1);
        wr = (kc == s_wr0);
        reset = rst;
        bus_a.rd_req = rd;  bus_b.rd_req = rd;
        bus_a.wr_req = wr;  bus_b.wr_req = wr;
        bus_a.la = s_la;    bus_b.la = s_la;
        bus_a.wdata = s_wd; bus_b.wdata = s_wd;
        bus_a.dcp_rdy = rdy_at(kc);  bus_b.dcp_rdy = rdy_at(kc);
        bus_a.dcp_din = din_at(kc);  bus_b.dcp_din = din_at(kc);
        if (!rst && m_valid)
            for (int i = 0; i < 2; i++)
                if ((rd || wr) && (!m_act[i] || kc > m_d[i])) accept(i, kc, wr);
        @(posedge clk);
        @(negedge clk);
        if (rst) begin
            kc = 0;
            m_valid = 1;
            for (int i = 0; i < 2; i++) begin
                m_act[i] = 0; m_rdata[i] = '0; m_dout[i] = '0;
            end
        end else begin
            kc++;
        end
    endtask

    task automatic run_scn(int rd0, int rd1, int wr0, int rst, bit la, logic [7:0] wd,
                           logic [7:0] din0, logic [7:0] din1, int dsw,
                           int r1lo, int r1hi, int r2lo, int r2hi, int len);
        s_rd0 = rd0; s_rd1 = rd1; s_wr0 = wr0; s_rst = rst; s_la = la; s_wd = wd;
        s_din0 = din0; s_din1 = din1; s_dsw = dsw;
        s_r1lo = r1lo; s_r1hi = r1hi; s_r2lo = r2lo; s_r2hi = r2hi;
        rst_done = 0;
        step(1'b1);
        clear_obs();
        for (int c = 0; c < len; c++) step(1'b0);
    endtask

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    endtask

    initial begin
        m_pw[0] = 2; m_stb[0] = 2;
        m_pw[1] = 3; m_stb[1] = 1;
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 0; m_rdata[i] = '0; m_dout[i] = '0;
        end
        clear_obs();

        // read address cycle, ready from k12
        run_scn(0, -1, -1, -1, 1'b1, 8'h00, 8'hA5, 8'hA5, 0, 12, 200, -1, -1, 30);
        chk("rd_ack_cycle", a_ack_first, 13);
        chk("rd_err", a_err_last, 0);
        chk("rd_mas_first", a_mas_first, 4);
        chk("rd_mas_last", a_mas_last, 12);
        chk("rd_mds_count", a_mds_cnt, 0);
        chk("rd_busy_first", a_busy_first, 1);
        chk("rd_rdata", int'(bus_a.rdata), 8'hA5);
        chk("sweep_mas_first", b_mas_first, 8);
        chk("sweep_ack_cycle", b_ack_first, 17);
        chk("sweep_tick1", b_tick1, 7);
        chk("sweep_tick2", b_tick2, 15);

        // read A5 first, then a data write at k20 with ready from k20+14
        run_scn(0, -1, 20, -1, 1'b0, 8'h3C, 8'hA5, 8'h3C, 20, 12, 14, 34, 60, 45);
        chk("wr_we_first", a_we_first, 24);
        chk("wr_we_last", a_we_last, 34);
        chk("wr_ack_cycle", a_ack_last, 35);
        chk("wr_rdata_kept", int'(bus_a.rdata), 8'hA5);
        chk("wr_dout", int'(bus_a.dcp_dout), 8'h3C);

        // read 5A, then a read at k20 that times out
        run_scn(0, 20, -1, -1, 1'b0, 8'h00, 8'h5A, 8'h5A, 0, 12, 13, -1, -1, 150);
        chk("tmo_ack_count", a_ack_cnt, 2);
        chk("tmo_ack_cycle", a_ack_last, 92);
        chk("tmo_err", a_err_last, 1);
        chk("tmo_rdata_kept", int'(bus_a.rdata), 8'h5A);

        // ready arrives on the same clock as the 15th WAIT tick
        run_scn(0, -1, -1, -1, 1'b1, 8'h00, 8'h77, 8'h77, 0, 71, 72, -1, -1, 80);
        chk("edge_ack_cycle", a_ack_first, 72);
        chk("edge_err", a_err_last, 0);
        chk("edge_rdata", int'(bus_a.rdata), 8'h77);

        // simultaneous read+write at k0, extra read at k6
        run_scn(0, 6, 0, -1, 1'b1, 8'h96, 8'h11, 8'h11, 0, 14, 100, -1, -1, 30);
        chk("sim_mas_first", a_mas_first, 4);
        chk("sim_we_last", a_we_last, 14);
        chk("sim_ack_count", a_ack_cnt, 1);
        chk("sim_ack_cycle", a_ack_first, 15);
        chk("sim_rdata_kept", int'(bus_a.rdata), 0);
        chk("sim_dout", int'(bus_a.dcp_dout), 8'h96);

        // reset at k8 in STROBE, then a fresh read
        run_scn(0, -1, -1, 8, 1'b1, 8'h00, 8'hC3, 8'hC3, 0, 12, 100, -1, -1, 40);
        chk("abort_outputs", int'(a_abort_vec), 0);
        chk("abort_ack_count", a_ack_cnt, 1);
        chk("abort_new_ack", a_ack_last, 13);
        chk("abort_new_rdata", int'(bus_a.rdata), 8'hC3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/dcp_bus_ctl.md
DCP_BUS_CTL -- requirements
Module: dcp_bus_ctl

Interface
REQ-001 SHALL have parameter PRE_W, default 2: prescaler width; one tick every 2^PRE_W clocks (range 1..8).
REQ-002 SHALL have parameter STB_TICKS, default 2: minimum strobe width in ticks (range 1..15).
REQ-003 SHALL have parameter TMO_TICKS, default 15: ticks allowed in WAIT before timeout (range 1..255).
REQ-004 SHALL have parameter DW, default 8: data width.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 rd_req  in  1  one-clock read request pulse.
REQ-008 wr_req  in  1  one-clock write request pulse.
REQ-009 la  in  1  cycle type, latched with the request: 1 = address cycle, 0 = data cycle.
REQ-010 wdata  in  DW  write data, latched with the request.
REQ-011 dcp_rdy  in  1  DCP ready/acknowledge.
REQ-012 dcp_din  in  DW  DCP read data.
REQ-013 mas, mds, dcp_we  out  1 each  address strobe, data strobe, write direction.
REQ-014 dcp_dout  out  DW  latched write data.
REQ-015 rdata  out  DW  last successfully read data.
REQ-016 ack, err, busy, tick  out  1 each  completion pulse, timeout flag, transaction in progress, prescaler tick.

Function
REQ-017 All outputs SHALL be registered; strobes SHALL be glitch-free.
REQ-018 Prescaler SHALL be a free-running PRE_W-bit up-counter; tick SHALL be 1 exactly when count = 2^PRE_W-1.
REQ-019 States SHALL be IDLE, SYNC, STROBE, WAIT, DONE.
REQ-020 IDLE: on rd_req or wr_req, SHALL latch la, wdata and direction (write if wr_req), then go to SYNC; with both requests high, write SHALL win and the read SHALL be dropped.
REQ-021 Requests arriving outside IDLE SHALL be ignored (not queued).
REQ-022 SYNC: SHALL wait for tick, then go to STROBE on the next clock.
REQ-023 STROBE: SHALL assert mas if latched la = 1, else mds; SHALL leave on the clock after the STB_TICKS-th tick seen in STROBE, so the strobe is high for exactly STB_TICKS*2^PRE_W clocks before WAIT.
REQ-024 WAIT: strobe SHALL stay asserted; dcp_rdy SHALL be sampled only here.
REQ-025 WAIT: dcp_rdy = 1 SHALL move to DONE and, for reads, load dcp_din into rdata.
REQ-026 WAIT: if the TMO_TICKS-th tick in WAIT arrives with dcp_rdy = 0, SHALL move to DONE with timeout set; if dcp_rdy = 1 on that same cycle, ready SHALL win with no timeout.
REQ-027 DONE: mas and mds SHALL be 0, ack SHALL be 1 for exactly one clock, and err SHALL equal the timeout flag in that clock; the next state SHALL be IDLE.
REQ-028 rdata SHALL be unchanged on writes and on timed-out reads.
REQ-029 dcp_we SHALL equal the latched direction in STROBE and WAIT and be 0 otherwise.
REQ-030 dcp_dout SHALL hold the latched wdata from request until the next request.
REQ-031 busy SHALL be 1 in SYNC, STROBE, WAIT and DONE.
REQ-032 mas and mds SHALL never both be 1.

Reset
REQ-033 reset = 1 SHALL force IDLE, prescaler 0, and mas, mds, dcp_we, ack, err, busy, tick, dcp_dout, rdata = 0 on the next clock.
REQ-034 reset mid-transaction SHALL abort with no ack or err pulse.
REQ-035 reset SHALL take priority over every request.

Verification (defaults; cycle k = k-th clock after reset release, prescaler count = k mod 4)
REQ-036 Read address cycle:
- rd_req = 1, la = 1 at k0; dcp_rdy = 1 from k12; dcp_din = 8'hA5.
- Required: busy 1 from k1; mas 1 for k4..k12; mds 0 throughout.
- Required at k13: ack = 1, err = 0; rdata = 8'hA5 from k13.
REQ-037 Write data cycle:
- wr_req = 1, la = 0, wdata = 8'h3C at k0; dcp_rdy = 1 from k14.
- Required: mds and dcp_we 1 for k4..k14; dcp_dout = 8'h3C.
- Required: ack at k15; rdata unchanged.
REQ-038 Timeout:
- rd_req at k0; dcp_rdy held 0.
- Required: 15th WAIT tick at k71; ack = 1 and err = 1 at k72; rdata unchanged.
- Required: dcp_rdy rising exactly at k71 gives ack at k72 with err = 0.
REQ-039 Simultaneous requests and ignored requests:
- rd_req and wr_req both 1 at k0. Required: write transaction.
- Extra rd_req at k6. Required: ignored; only one ack.
REQ-040 Reset abort: reset at k8 during STROBE. Required: all outputs 0 at k9, no ack; new rd_req completes normally.
REQ-041 Parameter sweep: PRE_W = 3, STB_TICKS = 1. Required: strobe width in STROBE exactly 8 clocks; tick period 8.
